avalon_multi_timer: RTL and testbench



---
 rtl/avalon_multi_timer.sv | 170 +++++++++++++++++
 tb/tb_avalon_multi_timer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_multi_timer.sv
// Multi-channel interval timer on an Avalon-MM slave port with SYNC start and PENDING vector.
// Latency: writes act on the strobe edge; readdata is registered one cycle after address; irq is combinational from TO/ITO.
// Backpressure: none; the slave has no wait states and accepts a write every cycle.
module avalon_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int COUNT_W      = 32,
    parameter int PRESCALE_W   = 8,
    parameter int RESET_PERIOD = 49999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [5:0] SYNC_ADDR    = 6'd62;
    localparam logic [5:0] PENDING_ADDR = 6'd63;

    typedef struct packed {
        logic [COUNT_W-1:0]    period;
        logic [COUNT_W-1:0]    counter;
        logic [COUNT_W-1:0]    snap;
        logic [PRESCALE_W-1:0] pre_cnt;
        logic [PRESCALE_W-1:0] prescale;
        logic                  ito;
        logic                  cont;
        logic                  run;
        logic                  to;
    } chan_t;

    chan_t ch_q [NUM_CH];

    logic              wr_en;
    logic [NUM_CH-1:0] to_clr;
    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] period_wr;
    logic [NUM_CH-1:0] snap_wr;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] timeout;
    logic [31:0]       rd_mux;

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        to_clr    = '0;
        ctrl_wr   = '0;
        period_wr = '0;
        snap_wr   = '0;
        start     = '0;
        stop      = '0;
        tick      = '0;
        timeout   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && address[5:2] == 4'(c)) begin
                case (address[1:0])
                    2'd0:    to_clr[c]    = writedata[0];
                    2'd1:    ctrl_wr[c]   = 1'b1;
                    2'd2:    period_wr[c] = 1'b1;
                    default: snap_wr[c]   = 1'b1;
                endcase
            end
            start[c]   = (ctrl_wr[c] & writedata[2])
                       | (wr_en && address == SYNC_ADDR && writedata[c]);
            stop[c]    = ctrl_wr[c] & writedata[3];
            tick[c]    = ch_q[c].run && ch_q[c].pre_cnt == '0;
            timeout[c] = tick[c] && ch_q[c].counter == '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_q[c].period   <= COUNT_W'(RESET_PERIOD);
                ch_q[c].counter  <= COUNT_W'(RESET_PERIOD);
                ch_q[c].snap     <= '0;
                ch_q[c].pre_cnt  <= '0;
                ch_q[c].prescale <= '0;
                ch_q[c].ito      <= 1'b0;
                ch_q[c].cont     <= 1'b0;
                ch_q[c].run      <= 1'b0;
                ch_q[c].to       <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // A PERIOD write force-reloads and stops the channel, overriding any start.
                if (period_wr[c]) begin
                    ch_q[c].period  <= writedata[COUNT_W-1:0];
                    ch_q[c].counter <= writedata[COUNT_W-1:0];
                    ch_q[c].pre_cnt <= ch_q[c].prescale;
                    ch_q[c].run     <= 1'b0;
                end else begin
                    if (tick[c]) begin
                        ch_q[c].pre_cnt <= ch_q[c].prescale;
                        ch_q[c].counter <= timeout[c] ? ch_q[c].period
                                                      : ch_q[c].counter - COUNT_W'(1);
                    end else if (ch_q[c].run) begin
                        ch_q[c].pre_cnt <= ch_q[c].pre_cnt - PRESCALE_W'(1);
                    end
                    if (start[c]) begin
                        ch_q[c].run <= 1'b1;
                    end else if (stop[c] || (timeout[c] && !ch_q[c].cont)) begin
                        ch_q[c].run <= 1'b0;
                    end
                end

                // Timeout set beats a same-cycle software clear so no event is lost.
                if (timeout[c]) begin
                    ch_q[c].to <= 1'b1;
                end else if (to_clr[c]) begin
                    ch_q[c].to <= 1'b0;
                end

                if (ctrl_wr[c]) begin
                    ch_q[c].ito      <= writedata[0];
                    ch_q[c].cont     <= writedata[1];
                    ch_q[c].prescale <= writedata[8 +: PRESCALE_W];
                end

                if (snap_wr[c]) begin
                    ch_q[c].snap <= ch_q[c].counter;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            irq_vec[c] = ch_q[c].to & ch_q[c].ito;
        end
    end

    assign irq = |irq_vec;

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (address[5:2] == 4'(c)) begin
                case (address[1:0])
                    2'd0: rd_mux = {30'b0, ch_q[c].run, ch_q[c].to};
                    2'd1: begin
                        rd_mux[8 +: PRESCALE_W] = ch_q[c].prescale;
                        rd_mux[1]               = ch_q[c].cont;
                        rd_mux[0]               = ch_q[c].ito;
                    end
                    2'd2:    rd_mux[COUNT_W-1:0] = ch_q[c].period;
                    default: rd_mux[COUNT_W-1:0] = ch_q[c].snap;
                endcase
            end
        end
        if (address == PENDING_ADDR) begin
            rd_mux[NUM_CH-1:0] = irq_vec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Bench for avalon_multi_timer: register access, timing of timeouts, SYNC start, collisions and reset.
module tb_avalon_multi_timer;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [5:0]        address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] act_q [$];
    string       name_q [$];

    always #5 clk = ~clk;

    avalon_multi_timer #(
        .NUM_CH(NUM_CH), .COUNT_W(32), .PRESCALE_W(8), .RESET_PERIOD(49999)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .irq_vec(irq_vec)
    );

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
    endtask

    // Expected value is queued with the address; the registered response is queued after the edge.
    task automatic bus_read(input logic [5:0] a, input logic [31:0] e, input string nm);
        address = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        act_q.push_back(readdata);
    endtask

    task automatic test_reset();
        logic [31:0] e, a;
        string nm;
        #1;
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0 || irq_vec !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: readdata=%h irq=%b irq_vec=%b expected 0/0/0", readdata, irq, irq_vec);
        end
        tick_n(2);
        reset = 1'b0;
        tick_n(1);
        bus_read(6'd2, 32'd49999, "ch0_period_reset");
        bus_read(6'd0, 32'd0, "ch0_status_reset");
        bus_read(6'd1, 32'd0, "ch0_control_reset");
        bus_read(6'd3, 32'd0, "ch0_snap_reset");
        bus_read(6'd14, 32'd49999, "ch3_period_reset");
        bus_read(6'd63, 32'd0, "pending_reset");
        bus_read(6'd16, 32'd0, "unmapped_ch4");
        bus_write(6'd61, 32'hFFFF_FFFF);
        bus_read(6'd61, 32'd0, "unmapped_61");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: readdata=%h expected %h", nm, a, e); end
        end
        address = 6'd2;
        #2;
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL read_latency_before_edge: readdata=%h expected 00000000", readdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if (readdata !== 32'd49999) begin
            errors++;
            $display("FAIL read_latency_after_edge: readdata=%h expected %h", readdata, 32'd49999);
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: irq=%b expected 0", irq); end
    endtask

    task automatic test_continuous();
        logic [31:0] e, a;
        string nm;
        bus_write(6'd6, 32'd4);
        bus_write(6'd5, 32'h7);
        for (int i = 1; i <= 5; i++) begin
            tick_n(1);
            checks++;
            if (irq_vec[1] !== (i == 5) || irq !== (i == 5)) begin
                errors++;
                $display("FAIL ch1_first_timeout cycle %0d: irq_vec[1]=%b irq=%b expected %b", i, irq_vec[1], irq, i == 5);
            end
        end
        bus_write(6'd4, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick_n(1);
            checks++;
            if (irq_vec[1] !== (i == 4)) begin
                errors++;
                $display("FAIL ch1_second_timeout cycle %0d: irq_vec[1]=%b expected %b", i, irq_vec[1], i == 4);
            end
        end
        bus_write(6'd5, 32'h8);
        bus_read(6'd4, 32'h1, "ch1_status_after_stop");
        bus_read(6'd5, 32'h0, "ch1_control_strobes_not_stored");
        bus_write(6'd4, 32'h1);
        bus_read(6'd4, 32'h0, "ch1_status_cleared");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: readdata=%h expected %h", nm, a, e); end
        end
    endtask

    task automatic test_oneshot_prescale();
        logic [31:0] e, a;
        string nm;
        bus_write(6'd1, 32'h300);
        bus_write(6'd2, 32'd2);
        bus_write(6'd1, 32'h305);
        for (int i = 1; i <= 12; i++) begin
            tick_n(1);
            checks++;
            if (irq_vec[0] !== (i == 12)) begin
                errors++;
                $display("FAIL ch0_prescaled_timeout cycle %0d: irq_vec[0]=%b expected %b", i, irq_vec[0], i == 12);
            end
        end
        bus_read(6'd0, 32'h1, "ch0_oneshot_status");
        bus_read(6'd1, 32'h301, "ch0_control_readback");
        bus_write(6'd3, 32'hDEAD_BEEF);
        bus_read(6'd3, 32'd2, "ch0_snap_reloaded");
        tick_n(5);
        bus_write(6'd3, 32'd0);
        bus_read(6'd3, 32'd2, "ch0_snap_held");
        bus_write(6'd0, 32'h1);
        bus_read(6'd0, 32'h0, "ch0_status_cleared");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: readdata=%h expected %h", nm, a, e); end
        end
    endtask

    task automatic test_sync();
        logic [31:0] e, a;
        logic [NUM_CH-1:0] ev;
        string nm;
        bus_write(6'd1, 32'h1);
        bus_write(6'd9, 32'h1);
        bus_write(6'd2, 32'd9);
        bus_write(6'd10, 32'd9);
        bus_write(6'd62, 32'h5);
        for (int i = 1; i <= 10; i++) begin
            if (i == 1) bus_read(6'd0, 32'h2, "ch0_run_after_sync");
            else if (i == 2) bus_read(6'd8, 32'h2, "ch2_run_after_sync");
            else tick_n(1);
            ev = (i == 10) ? 4'b0101 : 4'b0000;
            checks++;
            if (irq_vec !== ev) begin
                errors++;
                $display("FAIL sync_timeout cycle %0d: irq_vec=%b expected %b", i, irq_vec, ev);
            end
        end
        bus_read(6'd4, 32'h0, "ch1_idle_after_sync");
        bus_read(6'd12, 32'h0, "ch3_idle_after_sync");
        bus_read(6'd63, 32'h5, "pending_sync");
        bus_read(6'd0, 32'h1, "ch0_sync_oneshot_done");
        bus_write(6'd0, 32'h1);
        bus_write(6'd8, 32'h1);
        bus_read(6'd63, 32'h0, "pending_cleared");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: readdata=%h expected %h", nm, a, e); end
        end
    endtask

    task automatic test_clear_collision();
        logic [31:0] e, a;
        string nm;
        bus_write(6'd13, 32'h1);
        bus_write(6'd14, 32'd3);
        bus_write(6'd13, 32'h7);
        tick_n(3);
        checks++;
        if (irq_vec[3] !== 1'b0) begin
            errors++;
            $display("FAIL ch3_before_timeout: irq_vec[3]=%b expected 0", irq_vec[3]);
        end
        // This clear lands on the timeout edge.
        bus_write(6'd12, 32'h1);
        checks++;
        if (irq_vec[3] !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL ch3_set_beats_clear: irq_vec[3]=%b irq=%b expected 1/1", irq_vec[3], irq);
        end
        bus_write(6'd13, 32'h0A);
        checks++;
        if (irq !== 1'b0 || irq_vec !== 4'd0) begin
            errors++;
            $display("FAIL ch3_ito_mask: irq=%b irq_vec=%b expected 0/0000", irq, irq_vec);
        end
        bus_read(6'd12, 32'h1, "ch3_to_kept_when_masked");
        bus_write(6'd12, 32'h1);
        bus_read(6'd12, 32'h0, "ch3_to_cleared");
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL ch3_irq_after_clear: irq=%b expected 0", irq); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: readdata=%h expected %h", nm, a, e); end
        end
    endtask

    task automatic test_start_stop_period();
        logic [31:0] e, a;
        string nm;
        bus_write(6'd9, 32'hD);
        bus_read(6'd8, 32'h2, "ch2_start_wins_over_stop");
        tick_n(1);
        bus_write(6'd9, 32'h5);
        for (int i = 4; i <= 10; i++) begin
            tick_n(1);
            checks++;
            if (irq_vec[2] !== (i == 10)) begin
                errors++;
                $display("FAIL ch2_restart_no_effect cycle %0d: irq_vec[2]=%b expected %b", i, irq_vec[2], i == 10);
            end
        end
        bus_read(6'd8, 32'h1, "ch2_oneshot_after_restart");
        bus_write(6'd8, 32'h1);
        bus_write(6'd9, 32'h0);
        bus_write(6'd62, 32'h1);
        bus_write(6'd2, 32'd7);
        bus_read(6'd0, 32'h0, "ch0_period_write_stops");
        tick_n(3);
        bus_write(6'd3, 32'd0);
        bus_read(6'd3, 32'd7, "ch0_counter_reloaded");
        bus_read(6'd2, 32'd7, "ch0_period_readback");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: readdata=%h expected %h", nm, a, e); end
        end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] e, a;
        string nm;
        int waited;
        bus_write(6'd5, 32'h7);
        waited = 0;
        while (irq !== 1'b1 && waited < 20) begin
            tick_n(1);
            waited++;
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL ch1_irq_before_reset: irq=%b expected 1 within 20 cycles", irq);
        end
        tick_n(2);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0 || irq_vec !== 4'd0 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: irq=%b irq_vec=%b readdata=%h expected 0/0000/0", irq, irq_vec, readdata);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read(6'd4, 32'h0, "ch1_status_after_reset");
        bus_read(6'd6, 32'd49999, "ch1_period_after_reset");
        bus_read(6'd5, 32'h0, "ch1_control_after_reset");
        bus_write(6'd7, 32'd0);
        bus_read(6'd7, 32'd49999, "ch1_counter_after_reset");
        tick_n(10);
        bus_read(6'd4, 32'h0, "ch1_stays_idle");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: readdata=%h expected %h", nm, a, e); end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_oneshot_prescale();
        test_sync();
        test_clear_collision();
        test_start_stop_period();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
